pe_row_sched: RTL

- Sequences one pe_con instance over a block of matrix rows: issues pe_start per row, waits for the PE's done, and writes each dot-product result into a result buffer at the row index.
- Sits between the host/AXI control logic (start/done) and pe_con; owns the row counter, the result-buffer write port and a per-row watchdog.

---
 rtl/pe_row_sched.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pe_row_sched.sv
// pe_row_sched: drives a single pe_con instance over a block of matrix rows.
// For each row it pulses pe_start, waits for a rising pe_done (bounded by a
// watchdog), then writes the PE result into the result buffer at the row
// index. A block ends with a one-cycle done pulse. A watchdog timeout ends the
// block early and sets a sticky err flag.
//
// Build option: define PE_ROW_SCHED_PERF_EN to enable the perf_cycles and
// perf_rows counters. When the option is off, both ports stay present and
// are tied to zero.
module pe_row_sched #(
  parameter int VECTOR_SIZE = 32,
  parameter int L_ROWS      = 4,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  // host side
  input  logic                   start,
  input  logic [L_ROWS:0]        num_rows,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  // pe_con side
  output logic                   pe_start,
  output logic [L_ROWS-1:0]      pe_row,
  input  logic                   pe_done,
  input  logic [VECTOR_SIZE-1:0] pe_result,
  // result buffer write port
  output logic                   res_we,
  output logic [L_ROWS-1:0]      res_addr,
  output logic [VECTOR_SIZE-1:0] res_data,
  // performance counters (zero unless PE_ROW_SCHED_PERF_EN)
  output logic [31:0]            perf_cycles,
  output logic [L_ROWS:0]        perf_rows
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // The watchdog holds WD_LAST during the final WAIT cycle. It reaches
  // all-ones on the edge that leaves WAIT, so a row gets 2^TIMEOUT_W-1
  // WAIT cycles before it is abandoned.
  localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {TIMEOUT_W{1'b1}} - WD_ONE;
  localparam logic [L_ROWS:0]      ROWS_ONE = {{L_ROWS{1'b0}}, 1'b1};
  localparam logic [L_ROWS-1:0]    ROW_ONE  = {{(L_ROWS-1){1'b0}}, 1'b1};

  logic [2:0]             state, state_next;
  logic [L_ROWS-1:0]      row, row_next;
  logic [L_ROWS:0]        rows_total, rows_total_next;
  logic [TIMEOUT_W-1:0]   wd, wd_next;
  logic                   err_q, err_next;
  logic [VECTOR_SIZE-1:0] data_q, data_next;
  logic                   pe_done_q;

  logic accept;
  logic timeout;
  logic last_row;
  logic start_ok;

  // Only a rising pe_done counts. A done level that is still held from the
  // previous row is therefore never taken as a second completion.
  assign accept   = pe_done & ~pe_done_q;
  assign timeout  = (wd == WD_LAST);
  assign last_row = ({1'b0, row} == (rows_total - ROWS_ONE));
  assign start_ok = (state == S_IDLE) && start;

  // Next-state and datapath decisions for the row sequencer
  always_comb begin
    state_next      = state;
    row_next        = row;
    rows_total_next = rows_total;
    wd_next         = wd;
    err_next        = err_q;
    data_next       = data_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          rows_total_next = num_rows;
          err_next        = 1'b0;
          row_next        = '0;
          state_next      = (num_rows == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_next    = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        wd_next = wd + WD_ONE;
        // When a completion and the timeout land in the same cycle, the
        // completion wins.
        if (accept) begin
          data_next  = pe_result;
          state_next = S_STORE;
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = S_DONE;
        end
      end
      S_STORE: begin
        if (last_row) begin
          state_next = S_DONE;
        end else begin
          row_next   = row + ROW_ONE;
          state_next = S_ISSUE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Sequencer state registers; reset drops any partially processed block
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      row        <= '0;
      rows_total <= '0;
      wd         <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state      <= state_next;
      row        <= row_next;
      rows_total <= rows_total_next;
      wd         <= wd_next;
      err_q      <= err_next;
      data_q     <= data_next;
    end
  end

  // Delayed copy of pe_done for rising-edge detection
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pe_done_q <= 1'b0;
    end else begin
      pe_done_q <= pe_done;
    end
  end

  // Outputs are decoded straight from registered state, so every pulse
  // lasts exactly one state.
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign err      = err_q;
  assign pe_start = (state == S_ISSUE);
  assign pe_row   = row;
  assign res_we   = (state == S_STORE);
  assign res_addr = row;
  assign res_data = data_q;

`ifdef PE_ROW_SCHED_PERF_EN
  logic [31:0]     perf_cycles_q;
  logic [L_ROWS:0] perf_rows_q;

  // Busy-cycle and completed-write counters; they hold after done until the
  // next accepted start clears them.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      perf_cycles_q <= '0;
      perf_rows_q   <= '0;
    end else if (start_ok) begin
      perf_cycles_q <= '0;
      perf_rows_q   <= '0;
    end else begin
      if (busy) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
      if (res_we) begin
        perf_rows_q <= perf_rows_q + ROWS_ONE;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_rows   = perf_rows_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign perf_cycles     = '0;
  assign perf_rows       = '0;
`endif

endmodule
